// File: rtl/mux_display.sv
// mux_display: time-multiplexed scan driver for six 7-segment digits.
// A prescaler divides the clock into digit slots; the six codes are latched
// once per frame so a digit never tears mid-scan, and each slot opens with a
// short all-off window to suppress ghosting on the shared segment bus.
// Optional build macro LEADING_ZERO_BLANK_EN: suppresses the hours-tens digit
// for a whole frame when it was captured as ZERO_CODE.
module mux_display #(
  parameter int         CLK_HZ       = 50000000,
  parameter int         SCAN_HZ      = 1000,
  parameter int         BLANK_CYCLES = 2,
  parameter logic [6:0] ZERO_CODE    = 7'b1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] s_Lsd,
  input  logic [6:0] s_Msd,
  input  logic [6:0] m_Lsd,
  input  logic [6:0] m_Msd,
  input  logic [6:0] h_Lsd,
  input  logic [6:0] h_Msd,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [6:0]    shadow [6];
  logic [6:0]    codes  [6];
  logic          slot_tick;
  logic          capture;
  logic          in_blank;
  logic          lz_blank;
  logic [5:0]    an_next;
  logic [6:0]    seg_next;

  assign codes[0] = s_Lsd;
  assign codes[1] = s_Msd;
  assign codes[2] = m_Lsd;
  assign codes[3] = m_Msd;
  assign codes[4] = h_Lsd;
  assign codes[5] = h_Msd;

  assign slot_tick = (prescaler == PW'(DIV - 1));
  // Capture coincides with the index wrapping back to digit 0.
  assign capture   = slot_tick && (idx == 3'd5);

  // With no blanking configured the comparison is dropped entirely.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (prescaler < PW'(BLANK_CYCLES));
    end
  endgenerate

  // Slot prescaler: counts 0..DIV-1 and wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (slot_tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Digit index: steps once per slot; any value past 5 recovers to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= 3'd0;
    end else if (slot_tick) begin
      idx <= (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    end
  end

  // Frame pulse: high for the single clock in which idx returns to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame <= 1'b0;
    end else begin
      frame <= capture;
    end
  end

  // Shadow registers: all six codes latched together at the frame boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) shadow[i] <= 7'b1111111;
    end else if (capture) begin
      for (int i = 0; i < 6; i++) shadow[i] <= codes[i];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic hz;

  // Leading-zero flag: decided once per frame from the captured hours tens.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hz <= 1'b0;
    end else if (capture) begin
      hz <= (h_Msd == ZERO_CODE);
    end
  end

  assign lz_blank = hz && (idx == 3'd5);
`else
  logic unused_zero_code;
  assign unused_zero_code = ^ZERO_CODE;
  assign lz_blank = 1'b0;
`endif

  // Output decode: all-off during the blank window, otherwise one digit low.
  always_comb begin
    an_next  = 6'b111111;
    seg_next = 7'b1111111;
    if (!in_blank && !lz_blank && (idx <= 3'd5)) begin
      an_next  = ~(6'b000001 << idx);
      seg_next = shadow[idx];
    end
  end

  // Registered drive of the digit selects and segment bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 6'b111111;
      seg <= 7'b1111111;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_mux_display.sv
// Bench for mux_display with DIV = 6 and one blank clock per slot.
// Expected per-clock {frame, an, seg} are pushed one frame at a time into a
// scoreboard queue and popped as the DUT clocks.
module tb_mux_display;

  localparam int CLK_HZ = 12;
  localparam int SCAN_HZ = 2;
  localparam int BLANK = 1;
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int FRAME_LEN = 6 * DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] s_Lsd, s_Msd, m_Lsd, m_Msd, h_Lsd, h_Msd;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame;

  typedef struct packed {
    logic       fr;
    logic [5:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] cur [6];   // codes the display is expected to be showing
  int         n_cmp = 0;
  int         n_bad = 0;

  mux_display #(
    .CLK_HZ(CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .BLANK_CYCLES(BLANK),
    .ZERO_CODE(7'b1000000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s_Lsd(s_Lsd),
    .s_Msd(s_Msd),
    .m_Lsd(m_Lsd),
    .m_Msd(m_Msd),
    .h_Lsd(h_Lsd),
    .h_Msd(h_Msd),
    .seg(seg),
    .an(an),
    .frame(frame)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task set_inputs(input logic [6:0] a, b, c, d, e, f);
    s_Lsd = a; s_Msd = b; m_Lsd = c; m_Msd = d; h_Lsd = e; h_Msd = f;
  endtask

  task latch_inputs();
    cur[0] = s_Lsd; cur[1] = s_Msd; cur[2] = m_Lsd;
    cur[3] = m_Msd; cur[4] = h_Lsd; cur[5] = h_Msd;
  endtask

  task blank_cur();
    for (int i = 0; i < 6; i++) cur[i] = 7'h7F;
  endtask

  // One frame window: clock k (1..36) after a frame pulse; slot d = (k-1)/6.
  task push_window();
    exp_t       e;
    logic       lzb;
    logic [5:0] one;
    one = 6'b000001;
`ifdef LEADING_ZERO_BLANK_EN
    lzb = (cur[5] == 7'b1000000);
`else
    lzb = 1'b0;
`endif
    for (int k = 1; k <= FRAME_LEN; k++) begin
      int d, pos;
      d = (k - 1) / DIV;
      pos = (k - 1) % DIV;
      e.fr = (k == FRAME_LEN);
      if (pos < BLANK || (lzb && d == 5)) begin
        e.an = 6'b111111;
        e.seg = 7'h7F;
      end else begin
        e.an = ~(one << d);
        e.seg = cur[d];
      end
      sb.push_back(e);
    end
  endtask

  task drain(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL %s: scoreboard empty, got frame/an/seg=%b/%b/%h", tag, frame, an, seg);
      end else begin
        e = sb.pop_front();
        if ({frame, an, seg} !== e) begin
          n_bad++;
          $display("FAIL %s clk%0d: frame/an/seg=%b/%b/%h required %b/%b/%h",
                   tag, i + 1, frame, an, seg, e.fr, e.an, e.seg);
        end
      end
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_bad++;
        $display("FAIL %s_onehot clk%0d: an=%b required at most one low bit", tag, i + 1, an);
      end
    end
  endtask

  task check_blank_now(input string tag);
    n_cmp++;
    if (an !== 6'b111111) begin
      n_bad++;
      $display("FAIL %s_an: an=%b required 111111", tag, an);
    end
    n_cmp++;
    if (seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL %s_seg: seg=%h required 7f", tag, seg);
    end
    n_cmp++;
    if (frame !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_frame: frame=%b required 0", tag, frame);
    end
  endtask

  task test_reset();
    set_inputs(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_blank_now("reset");
    @(negedge clock);
    reset = 1'b0;
    blank_cur();
    push_window();
    drain(FRAME_LEN, "reset_window");
    latch_inputs();
    push_window();
    drain(FRAME_LEN, "first_frame");
    $display("test_reset done: %0d compared", n_cmp);
  endtask

  task test_distinct();
    set_inputs(7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06);
    push_window();
    drain(FRAME_LEN, "distinct_pre");
    latch_inputs();
    push_window();
    drain(FRAME_LEN, "distinct_f1");
    push_window();
    drain(FRAME_LEN, "distinct_f2");
    $display("test_distinct done: %0d compared", n_cmp);
  endtask

  task test_midframe();
    push_window();
    drain(9, "midframe_a");
    m_Lsd = 7'h33;
    drain(FRAME_LEN - 9, "midframe_b");
    latch_inputs();
    push_window();
    drain(FRAME_LEN, "midframe_new");
    $display("test_midframe done: %0d compared", n_cmp);
  endtask

  task test_reset_mid();
    push_window();
    drain(21, "rstmid_pre");
    #2;
    reset = 1'b1;
    #1;
    check_blank_now("rstmid_async");
    sb.delete();
    @(posedge clock);
    #1;
    check_blank_now("rstmid_held");
    @(negedge clock);
    reset = 1'b0;
    blank_cur();
    push_window();
    drain(FRAME_LEN, "rstmid_blank");
    latch_inputs();
    push_window();
    drain(FRAME_LEN, "rstmid_recap");
    $display("test_reset_mid done: %0d compared", n_cmp);
  endtask

  task test_leading_zero();
    h_Msd = 7'b1000000;
    push_window();
    drain(FRAME_LEN, "lz_pre");
    latch_inputs();
    push_window();
    drain(FRAME_LEN, "lz_zero");
    h_Msd = 7'b1111001;
    push_window();
    drain(FRAME_LEN, "lz_zero2");
    latch_inputs();
    push_window();
    drain(FRAME_LEN, "lz_one");
    $display("test_leading_zero done: %0d compared", n_cmp);
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_midframe();
    test_reset_mid();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
